uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single uart_stream_tx byte stream between N_SRC producers, such as mapper_packetizer instances and a status/telemetry source. It grants one source at a time and holds the grant for a whole packet, ending at the byte flagged last, so packets never interleave on the wire. It forwards bytes over the ready/valid contract of uart_stream_tx. A watchdog reclaims the channel from a stalled source.

Parameters:
N_SRC, 4, number of requesting sources (2..16).
TIMEOUT_CYC, 100000, clk cycles a granted source may go without presenting a byte before its grant is aborted; 0 disables the watchdog.

Ports:
clk  in  1  fabric clock
rst  in  1  synchronous, active-high reset
req  in  N_SRC  per-source level: "I have a packet to send"
src_byte  in  8*N_SRC  flattened bytes; source i occupies [8*i+7:8*i]
src_vld  in  N_SRC  per-source byte valid
src_last  in  N_SRC  per-source: this byte ends the packet
src_rdy  out  N_SRC  per-source accept; only the granted bit can be 1
tx_byte  out  8  to uart_stream_tx.tx_byte
tx_vld  out  1  to uart_stream_tx.tx_vld
tx_rdy  in  1  from uart_stream_tx.tx_rdy
grant  out  N_SRC  one-hot registered grant; 0 when idle
abort  out  1  1-cycle pulse when the watchdog drops a grant
abort_cnt  out  16  saturating count of aborts

Behaviour:
- Reset state: grant=0, state=IDLE, rr_ptr=0, wd counter=0, abort=0, abort_cnt=0. Combinational outputs then read src_rdy=0, tx_vld=0, tx_byte=0.
- Transfer definition: a downstream byte moves on any cycle with tx_vld && tx_rdy. A source byte moves on the same cycle, and only for the granted source.
- States are IDLE, TAG (present only with the optional feature) and XFER.
- IDLE: if req!=0, pick the first set req bit searching upward from rr_ptr with wrap. Register it into grant and go to XFER, or to TAG when the feature is enabled. Latency from req to grant is 1 cycle. With req==0, stay in IDLE.
- XFER datapath (combinational pass-through, no buffering):
  - tx_byte = src_byte of the granted source.
  - tx_vld = src_vld of the granted source.
  - src_rdy[g] = tx_rdy; every other src_rdy bit is 0.
- Packet end: on a transfer with src_last[g]=1, return to IDLE, clear grant and set rr_ptr=(g+1) mod N_SRC. The next grant is therefore no earlier than 1 cycle later.
- Single-byte packets (vld and last on the first XFER cycle) are legal.
- Deasserting req[g] while granted is ignored. Only last or the watchdog ends the grant.
- Watchdog:
  - The counter resets on every transfer and on entry to XFER.
  - It increments only on cycles where src_vld[g]=0. Cycles where the source is valid but tx_rdy=0 are UART backpressure and neither count nor reset it.
  - When the counter reaches TIMEOUT_CYC-1: pulse abort, saturating-increment abort_cnt (holds at 16'hFFFF), clear grant, set rr_ptr=g+1 and go to IDLE.
  - No partial-packet marker is emitted.
  - With TIMEOUT_CYC=0 the watchdog never fires.
- Simultaneous events: a transfer with last on the watchdog's final cycle counts as a normal end; no abort is raised.
- Reset mid-packet returns to the reset state on the next edge. uart_stream_tx shares the same rst, so the in-flight frame is cut.
- Round-robin fairness: with all req held high, grants rotate 0,1,2,...,N_SRC-1,0.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined: after a grant, state TAG drives tx_byte={4'hA, g[3:0]} with tx_vld=1 and all src_rdy=0. On the transfer, go to XFER. The watchdog does not count in TAG.
- Undefined: TAG does not exist and IDLE goes directly to XFER. The wire carries packet bytes only.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding (IDLE/TAG/XFER);
  - TAG_NIBBLE=4'hA;
  - ABORT_CNT_W=16;
  - a function for the index width, clog2 of N_SRC with a minimum of 1.
- One sub-module, rr_pick: a combinational round-robin picker taking req and rr_ptr and producing a one-hot result plus a valid flag. It is reused by future arbiters.

Test Plan:
- Only source 2 requests a 3-byte packet 0x11,0x22,0x33 (last on 0x33): grant=0100 one cycle after req; UART line shows 3 frames in order; grant=0 after the 0x33 transfer.
- All 4 sources hold req with 2-byte packets: grant order is 0,1,2,3,0; no byte of one packet appears between bytes of another.
- Source 1 granted, src_vld held 0, TIMEOUT_CYC=50: abort pulses exactly 50 cycles after grant; abort_cnt=1; source 2 requesting gets the next grant.
- Source valid while UART is busy (tx_rdy=0 for 500 cycles, TIMEOUT_CYC=50): no abort; src_rdy stays 0 until tx_rdy=1.
- rst asserted mid-packet: next cycle grant=0, tx_vld=0, abort_cnt=0, rr_ptr=0; a fresh request from source 3 is granted.
- UART_ARB_TAG_EN defined, source 3 sends a single byte 0x5C: line shows 0xA3 then 0x5C; src_rdy[3] stays 0 during the tag byte.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART packet arbiter family.
// Optional tag-byte framing is enabled by defining UART_ARB_TAG_EN.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TAG  = 2'd1,
      ST_XFER = 2'd2
   } arb_state_t;

   localparam logic [3:0] TAG_NIBBLE  = 4'hA;
   localparam int         ABORT_CNT_W = 16;

   // Index width for n sources, never narrower than one bit.
   function automatic int idx_w(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
// Zero latency; no flow control, gnt is one-hot and vld flags any request.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic         vld
);

   logic [W:0] idx;

   always_comb begin
      gnt = '0;
      vld = 1'b0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + (W+1)'(k);
         if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
         if (!vld && req[idx[W-1:0]]) begin
            gnt[idx[W-1:0]] = 1'b1;
            vld             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter onto one UART byte stream, grant held until last byte or watchdog abort.
// Grant 1 cycle after req; bytes pass combinationally with src_rdy = tx_rdy for the granted source.
// UART_ARB_TAG_EN prefixes every packet with a {A, src} tag byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_SRC-1:0]       req,
   input  logic [8*N_SRC-1:0]     src_byte,
   input  logic [N_SRC-1:0]       src_vld,
   input  logic [N_SRC-1:0]       src_last,
   output logic [N_SRC-1:0]       src_rdy,
   output logic [7:0]             tx_byte,
   output logic                   tx_vld,
   input  logic                   tx_rdy,
   output logic [N_SRC-1:0]       grant,
   output logic                   abort,
   output logic [ABORT_CNT_W-1:0] abort_cnt
);

   localparam int          IDX_W   = idx_w(N_SRC);
   localparam logic [31:0] WD_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

   arb_state_t             state, state_nxt;
   logic [N_SRC-1:0]       grant_nxt;
   logic [IDX_W-1:0]       rr_ptr, rr_nxt;
   logic [31:0]            wd, wd_nxt;
   logic                   abort_nxt;
   logic [ABORT_CNT_W-1:0] cnt_nxt;

   logic [N_SRC-1:0]       pick_gnt;
   logic                   pick_vld;
   logic [IDX_W-1:0]       g_idx, g_inc;
   logic [7:0]             sel_byte;
   logic                   sel_vld, sel_last;

   rr_pick #(.N(N_SRC), .W(IDX_W)) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .vld (pick_vld)
   );

   // Mux the granted source; grant is one-hot so a priority loop is exact.
   always_comb begin
      g_idx    = '0;
      sel_byte = '0;
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant[i]) begin
            g_idx    = IDX_W'(i);
            sel_byte = src_byte[8*i +: 8];
            sel_vld  = src_vld[i];
            sel_last = src_last[i];
         end
      end
   end

   assign g_inc = (g_idx == IDX_W'(N_SRC - 1)) ? '0 : g_idx + IDX_W'(1);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      wd_nxt    = wd;
      abort_nxt = 1'b0;
      cnt_nxt   = abort_cnt;
      tx_byte   = '0;
      tx_vld    = 1'b0;
      src_rdy   = '0;

      case (state)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_nxt = pick_gnt;
               wd_nxt    = '0;
`ifdef UART_ARB_TAG_EN
               state_nxt = ST_TAG;
`else
               state_nxt = ST_XFER;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         ST_TAG: begin
            tx_byte = {TAG_NIBBLE, 4'(g_idx)};
            tx_vld  = 1'b1;
            if (tx_rdy) begin
               state_nxt = ST_XFER;
               wd_nxt    = '0;
            end
         end
`endif
         ST_XFER: begin
            tx_byte = sel_byte;
            tx_vld  = sel_vld;
            src_rdy = grant & {N_SRC{tx_rdy}};
            if (sel_vld && tx_rdy) begin
               wd_nxt = '0;
               if (sel_last) begin
                  state_nxt = ST_IDLE;
                  grant_nxt = '0;
                  rr_nxt    = g_inc;
               end
            end else if (!sel_vld && TIMEOUT_CYC != 0) begin
               // Valid-but-stalled cycles are UART backpressure and leave wd untouched.
               if (wd == WD_LAST) begin
                  abort_nxt = 1'b1;
                  if (abort_cnt != '1) cnt_nxt = abort_cnt + ABORT_CNT_W'(1);
                  state_nxt = ST_IDLE;
                  grant_nxt = '0;
                  rr_nxt    = g_inc;
               end else begin
                  wd_nxt = wd + 32'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         wd        <= '0;
         abort     <= 1'b0;
         abort_cnt <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         rr_ptr    <= rr_nxt;
         wd        <= wd_nxt;
         abort     <= abort_nxt;
         abort_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: N_SRC=4, TIMEOUT_CYC=50, honours UART_ARB_TAG_EN.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 50;
`ifdef UART_ARB_TAG_EN
   localparam int WD_DIFF = TO + 1;
`else
   localparam int WD_DIFF = TO;
`endif

   logic           clk, rst, tx_rdy, tx_vld, abort;
   logic [N-1:0]   req, src_vld, src_last, src_rdy, grant;
   logic [8*N-1:0] src_byte;
   logic [7:0]     tx_byte;
   logic [15:0]    abort_cnt;

   uart_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .src_byte(src_byte), .src_vld(src_vld),
      .src_last(src_last), .src_rdy(src_rdy), .tx_byte(tx_byte), .tx_vld(tx_vld),
      .tx_rdy(tx_rdy), .grant(grant), .abort(abort), .abort_cnt(abort_cnt)
   );

   int checks = 0, errors = 0, cyc = 0;
   logic [8:0]   srcq [N][$];     // {last, byte} per source
   logic [9:0]   exp_q[$];        // {tag, last, byte} in wire order
   logic [N-1:0] exp_g[$];
   logic [N-1:0] vld_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic queue_pkt(input int s, input logic [31:0] b, input int n, input bit exp_data);
      logic [8:0] e;
`ifdef UART_ARB_TAG_EN
      exp_q.push_back({1'b1, 1'b0, 4'hA, 4'(s)});
`endif
      for (int k = 0; k < n; k++) begin
         e = {(k == n - 1), b[8*k +: 8]};
         srcq[s].push_back(e);
         if (exp_data) exp_q.push_back({1'b0, e});
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) srcq[i].delete();
      exp_q.delete();
      exp_g.delete();
      chk("rst grant", 32'(grant), 0);
      chk("rst tx_vld", 32'(tx_vld), 0);
      chk("rst tx_byte", 32'(tx_byte), 0);
      chk("rst src_rdy", 32'(src_rdy), 0);
      chk("rst abort", 32'(abort), 0);
      chk("rst abort_cnt", 32'(abort_cnt), 0);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input int budget, input bit stall);
      bit done = 0;
      for (int k = 0; k < budget && !done; k++) begin
         @(posedge clk); #2;
         if (stall) tx_rdy = (k % 3 != 2);
         if (exp_q.size() == 0 && exp_g.size() == 0 && grant == 0 &&
             srcq[0].size() == 0 && srcq[1].size() == 0 &&
             srcq[2].size() == 0 && srcq[3].size() == 0) done = 1;
      end
      tx_rdy = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain timeout: %0d bytes and %0d grants still expected", exp_q.size(), exp_g.size());
      end
   endtask

   // Source models: advance on the accepted byte, present the queue head.
   initial begin
      logic [N-1:0] fire;
      req = '0; src_vld = '0; src_last = '0; src_byte = '0;
      forever begin
         @(negedge clk);
         fire = src_rdy & src_vld;
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            req[i]      = !rst && srcq[i].size() > 0;
            src_vld[i]  = req[i] && vld_en[i];
            src_last[i] = req[i] ? srcq[i][0][8] : 1'b0;
            src_byte[8*i +: 8] = req[i] ? srcq[i][0][7:0] : 8'h00;
         end
      end
   end

   // Monitor: wire bytes, grant sequence and release after a last byte.
   initial begin
      logic [9:0]   e;
      logic [N-1:0] prev_g = '0;
      bit           last_pend = 0;
      forever begin
         @(negedge clk);
         if (last_pend) chk("grant released after last", 32'(grant), 0);
         last_pend = 0;
         if (tx_vld && tx_rdy) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected byte: got %0h expected none", tx_byte);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", 32'(tx_byte), 32'(e[7:0]));
               if (e[9]) chk("src_rdy during tag", 32'(src_rdy), 0);
               last_pend = e[8];
            end
         end
         if (grant != 0 && prev_g == 0) begin
            if (exp_g.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected grant: got %0h expected none", grant);
            end else chk("grant order", 32'(grant), 32'(exp_g.pop_front()));
         end
         prev_g = grant;
      end
   end

   initial begin
      int t_g, t_a, bad_abort, bad_rdy;
      bit hit;
      rst = 1'b1; tx_rdy = 1'b1; vld_en = '1;
      apply_reset();

      // Source 2 alone, 3-byte packet; grant one cycle after req.
      queue_pkt(2, 32'h00332211, 3, 1);
      exp_g.push_back(4'b0100);
      @(posedge clk); #2;
      chk("grant before latency", 32'(grant), 0);
      @(posedge clk); #2;
      chk("grant latency", 32'(grant), 32'b0100);
      wait_drain(100, 0);

      // Reset in the middle of a source-1 packet.
      queue_pkt(1, 32'hA4A3A2A1, 4, 1);
      exp_g.push_back(4'b0010);
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 2) hit = 1;
      end
      chk("mid-packet progress", 32'(hit), 1);
      tx_rdy = 1'b0;
      apply_reset();
      tx_rdy = 1'b1;
      // rr_ptr back at 0: source 1 wins over source 3, then 3 follows.
      queue_pkt(1, 32'h00001C1B, 2, 1);
      queue_pkt(3, 32'h00003B3A, 2, 1);
      exp_g.push_back(4'b0010);
      exp_g.push_back(4'b1000);
      wait_drain(100, 0);

      // All four requesting, source 0 twice: rotation 0,1,2,3,0 with UART stalls.
      queue_pkt(0, 32'h00000201, 2, 1);
      queue_pkt(1, 32'h00001211, 2, 1);
      queue_pkt(2, 32'h00002221, 2, 1);
      queue_pkt(3, 32'h00003231, 2, 1);
      queue_pkt(0, 32'h00000605, 2, 1);
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
      exp_g.push_back(4'b0100); exp_g.push_back(4'b1000);
      exp_g.push_back(4'b0001);
      wait_drain(300, 1);

      // Watchdog: source 1 granted but never valid; source 2 waiting.
      apply_reset();
      vld_en[1] = 1'b0;
      queue_pkt(1, 32'h0000EEEE, 2, 0);
      queue_pkt(2, 32'h00004241, 2, 1);
      exp_g.push_back(4'b0010);
      exp_g.push_back(4'b0100);
      t_g = -1000; t_a = -1;
      for (int k = 0; k < 300 && t_a < 0; k++) begin
         @(posedge clk); #2;
         if (grant == 4'b0010 && t_g < 0) t_g = cyc;
         if (abort) t_a = cyc;
      end
      chk("abort delay", 32'(t_a - t_g), 32'(WD_DIFF));
      chk("abort_cnt after abort", 32'(abort_cnt), 1);
      srcq[1].delete();
      @(posedge clk); #2;
      chk("abort pulse width", 32'(abort), 0);
      vld_en[1] = 1'b1;
      wait_drain(100, 0);

      // UART backpressure longer than the timeout must not abort.
      tx_rdy = 1'b0;
      queue_pkt(0, 32'h00000B0A, 2, 1);
      exp_g.push_back(4'b0001);
      bad_abort = 0; bad_rdy = 0;
      for (int k = 0; k < 500; k++) begin
         @(posedge clk); #2;
         if (abort) bad_abort++;
         if (src_rdy != 0) bad_rdy++;
      end
      chk("abort under backpressure", 32'(bad_abort), 0);
      chk("src_rdy under backpressure", 32'(bad_rdy), 0);
      chk("tx_vld under backpressure", 32'(tx_vld), 1);
      chk("grant under backpressure", 32'(grant), 32'b0001);
      tx_rdy = 1'b1;
      wait_drain(100, 0);

      // Single-byte packet from source 3 (tag byte first when enabled).
      queue_pkt(3, 32'h0000005C, 1, 1);
      exp_g.push_back(4'b1000);
      wait_drain(100, 0);

      chk("abort_cnt held", 32'(abort_cnt), 1);
      apply_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
